fetch_pipe_ctrl: RTL and testbench

- Consumer end of the hazard-control interface: owns the PC register, the IF/ID pipeline register and the ID/EX control-word register.
- Executes PC_Hold / IF_ID_Hold / IF_Flush / ID_EX_Flush from the hazard unit, together with jump and branch redirects resolved in ID.
- Inserts NOP bubbles and keeps saturating stall and flush counters for debug.
- Sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

---
 rtl/fetch_pipe_ctrl.sv | 64 ++++++
 tb/tb_fetch_pipe_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_pipe_ctrl.sv
// fetch_pipe_ctrl: PC, IF/ID and ID/EX registers driven by hazard holds/flushes and ID-stage redirects.
module fetch_pipe_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int CTRL_W = 9,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_Hold,
  input  logic              IF_ID_Hold,
  input  logic              IF_Flush,
  input  logic              ID_EX_Flush,
  input  logic              Jump,
  input  logic [XLEN-1:0]   Jump_Target,
  input  logic              Branch_Taken,
  input  logic [XLEN-1:0]   Branch_Target,
  input  logic [XLEN-1:0]   IM_Instr,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  output logic [XLEN-1:0]   IM_Addr,
  output logic [XLEN-1:0]   IF_ID_Instr,
  output logic [XLEN-1:0]   IF_ID_PC4,
  output logic              IF_ID_Valid,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              ID_EX_Valid,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [XLEN-1:0] pc, pc_plus4, pc_next, jump_tgt, branch_tgt;
  logic redirect, squash;
  assign jump_tgt = {Jump_Target[XLEN-1:2], 2'b00};
  assign branch_tgt = {Branch_Target[XLEN-1:2], 2'b00};
  assign pc_plus4 = pc + FOUR;
  assign pc_next = PC_Hold ? pc : Jump ? jump_tgt : Branch_Taken ? branch_tgt : pc_plus4;
  assign redirect = !PC_Hold && (Jump || Branch_Taken);
  // A held IF/ID keeps a stalled branch in ID, so its squash waits until release
  assign squash = !IF_ID_Hold && (IF_Flush || redirect);
  assign IM_Addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      IF_ID_Instr <= '0;
      IF_ID_PC4 <= '0;
      IF_ID_Valid <= 1'b0;
      ID_EX_Ctrl <= '0;
      ID_EX_Valid <= 1'b0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      pc <= pc_next;
      if (!IF_ID_Hold) begin
        IF_ID_Instr <= squash ? '0 : IM_Instr;
        IF_ID_PC4 <= squash ? '0 : pc_plus4;
        IF_ID_Valid <= !squash;
      end
      ID_EX_Ctrl <= (ID_EX_Flush || !IF_ID_Valid) ? '0 : ID_Ctrl;
      ID_EX_Valid <= !ID_EX_Flush && IF_ID_Valid;
      if (PC_Hold && ~&Stall_Count) Stall_Count <= Stall_Count + ONE;
      if (squash && ~&Flush_Count) Flush_Count <= Flush_Count + ONE;
    end
  end
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// tb_fetch_pipe_ctrl: directed scenarios with hand-computed expectations for fetch_pipe_ctrl.
module tb_fetch_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pc_hold = 1'b0, if_id_hold = 1'b0, if_flush = 1'b0, id_ex_flush = 1'b0;
  logic jump = 1'b0, branch_taken = 1'b0;
  logic [31:0] jump_target = '0, branch_target = '0;
  logic [31:0] im_instr;
  logic [8:0] id_ctrl = 9'h155;
  logic [31:0] im_addr, if_id_instr, if_id_pc4;
  logic if_id_valid, id_ex_valid;
  logic [8:0] id_ex_ctrl;
  logic [15:0] stall_count, flush_count;
  int checks = 0;
  int errors = 0;

  fetch_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .PC_Hold(pc_hold), .IF_ID_Hold(if_id_hold),
    .IF_Flush(if_flush), .ID_EX_Flush(id_ex_flush), .Jump(jump),
    .Jump_Target(jump_target), .Branch_Taken(branch_taken),
    .Branch_Target(branch_target), .IM_Instr(im_instr), .ID_Ctrl(id_ctrl),
    .IM_Addr(im_addr), .IF_ID_Instr(if_id_instr), .IF_ID_PC4(if_id_pc4),
    .IF_ID_Valid(if_id_valid), .ID_EX_Ctrl(id_ex_ctrl), .ID_EX_Valid(id_ex_valid),
    .Stall_Count(stall_count), .Flush_Count(flush_count)
  );

  always #5 clk = ~clk;
  // Instruction memory: word at address a is 0x2008_0001 + a
  assign im_instr = 32'h2008_0001 + im_addr;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    step();
    step();
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", im_addr, 32'h0); end
    checks++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_ifid got %h/%h/%b exp 0/0/0", if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (id_ex_ctrl !== 9'h0 || id_ex_valid !== 1'b0) begin errors++; $display("FAIL rst_idex got %h/%b exp 0/0", id_ex_ctrl, id_ex_valid); end
    checks++; if (stall_count !== 16'h0 || flush_count !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", stall_count, flush_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    step();
    checks++; if (im_addr !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h exp %h", im_addr, 32'h4); end
    checks++; if (if_id_instr !== 32'h2008_0001 || if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_ifid1 got %h/%h/%b exp 20080001/4/1", if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (id_ex_valid !== 1'b0) begin errors++; $display("FAIL seq_idex1 got %b exp 0", id_ex_valid); end
    step();
    checks++; if (im_addr !== 32'h8 || if_id_instr !== 32'h2008_0005 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL seq_2 got %h/%h/%h exp 8/20080005/8", im_addr, if_id_instr, if_id_pc4); end
    checks++; if (id_ex_ctrl !== 9'h155 || id_ex_valid !== 1'b1) begin errors++; $display("FAIL seq_idex2 got %h/%b exp 155/1", id_ex_ctrl, id_ex_valid); end
    step();
    checks++; if (im_addr !== 32'hC) begin errors++; $display("FAIL seq_pc3 got %h exp %h", im_addr, 32'hC); end
    step();
  endtask

  task automatic test_load_use_stall;
    checks++; if (im_addr !== 32'h10 || if_id_instr !== 32'h2008_000D) begin errors++; $display("FAIL stall_pre got %h/%h exp 10/2008000d", im_addr, if_id_instr); end
    pc_hold = 1'b1; if_id_hold = 1'b1; id_ex_flush = 1'b1;
    step();
    pc_hold = 1'b0; if_id_hold = 1'b0; id_ex_flush = 1'b0;
    checks++; if (im_addr !== 32'h10) begin errors++; $display("FAIL stall_pc got %h exp %h", im_addr, 32'h10); end
    checks++; if (if_id_instr !== 32'h2008_000D || if_id_pc4 !== 32'h10 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid got %h/%h/%b exp 2008000d/10/1", if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (id_ex_ctrl !== 9'h0 || id_ex_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble got %h/%b exp 0/0", id_ex_ctrl, id_ex_valid); end
    checks++; if (stall_count !== 16'd1 || flush_count !== 16'd0) begin errors++; $display("FAIL stall_cnt got %h/%h exp 1/0", stall_count, flush_count); end
    step();
    checks++; if (im_addr !== 32'h14 || if_id_instr !== 32'h2008_0011 || if_id_pc4 !== 32'h14) begin errors++; $display("FAIL stall_post got %h/%h/%h exp 14/20080011/14", im_addr, if_id_instr, if_id_pc4); end
  endtask

  task automatic test_branch;
    step(); step(); step();
    checks++; if (im_addr !== 32'h20) begin errors++; $display("FAIL br_pre got %h exp %h", im_addr, 32'h20); end
    branch_taken = 1'b1; branch_target = 32'h43;
    step();
    branch_taken = 1'b0;
    checks++; if (im_addr !== 32'h40) begin errors++; $display("FAIL br_pc got %h exp %h", im_addr, 32'h40); end
    checks++; if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL br_squash got %h/%h/%b exp 0/0/0", if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (flush_count !== 16'd1) begin errors++; $display("FAIL br_flushcnt got %h exp 1", flush_count); end
    step();
    checks++; if (im_addr !== 32'h44 || if_id_instr !== 32'h2008_0041 || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1) begin errors++; $display("FAIL br_target_fetch got %h/%h/%h/%b exp 44/20080041/44/1", im_addr, if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (id_ex_valid !== 1'b0 || id_ex_ctrl !== 9'h0) begin errors++; $display("FAIL br_idex_bubble got %h/%b exp 0/0", id_ex_ctrl, id_ex_valid); end
  endtask

  task automatic test_branch_held;
    branch_taken = 1'b1; branch_target = 32'h80;
    pc_hold = 1'b1; if_id_hold = 1'b1; if_flush = 1'b1;
    step();
    pc_hold = 1'b0; if_id_hold = 1'b0; if_flush = 1'b0;
    checks++; if (im_addr !== 32'h44 || if_id_instr !== 32'h2008_0041 || if_id_valid !== 1'b1) begin errors++; $display("FAIL held_br_state got %h/%h/%b exp 44/20080041/1", im_addr, if_id_instr, if_id_valid); end
    checks++; if (flush_count !== 16'd1 || stall_count !== 16'd2) begin errors++; $display("FAIL held_br_cnt got %h/%h exp 2/1", stall_count, flush_count); end
    step();
    branch_taken = 1'b0;
    checks++; if (im_addr !== 32'h80 || if_id_valid !== 1'b0 || flush_count !== 16'd2) begin errors++; $display("FAIL held_br_release got %h/%b/%h exp 80/0/2", im_addr, if_id_valid, flush_count); end
    step();
    checks++; if (im_addr !== 32'h84 || if_id_instr !== 32'h2008_0081 || flush_count !== 16'd2) begin errors++; $display("FAIL held_br_one_squash got %h/%h/%h exp 84/20080081/2", im_addr, if_id_instr, flush_count); end
  endtask

  task automatic test_jump_priority;
    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    checks++; if (im_addr !== 32'h100 || flush_count !== 16'd3) begin errors++; $display("FAIL jump_prio got %h/%h exp 100/3", im_addr, flush_count); end
  endtask

  task automatic test_wrap;
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    jump = 1'b0;
    checks++; if (im_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", im_addr); end
    step();
    checks++; if (im_addr !== 32'h0 || if_id_instr !== 32'h2007_FFFD || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc got %h/%h/%h/%b exp 0/2007fffd/0/1", im_addr, if_id_instr, if_id_pc4, if_id_valid); end
  endtask

  task automatic test_saturation;
    pc_hold = 1'b1;
    for (int i = 0; i < 65541; i++) step();
    pc_hold = 1'b0;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h exp ffff", stall_count); end
    checks++; if (im_addr !== 32'h0 || if_id_instr !== 32'h2008_0001) begin errors++; $display("FAIL held_reload got %h/%h exp 0/20080001", im_addr, if_id_instr); end
    step();
    checks++; if (im_addr !== 32'h4 || stall_count !== 16'hFFFF || flush_count !== 16'd4) begin errors++; $display("FAIL post_sat got %h/%h/%h exp 4/ffff/4", im_addr, stall_count, flush_count); end
  endtask

  task automatic test_async_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (im_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ifid got %h/%h/%h/%b exp 0/0/0/0", im_addr, if_id_instr, if_id_pc4, if_id_valid); end
    checks++; if (id_ex_ctrl !== 9'h0 || id_ex_valid !== 1'b0 || stall_count !== 16'h0 || flush_count !== 16'h0) begin errors++; $display("FAIL async_rst_rest got %h/%b/%h/%h exp 0/0/0/0", id_ex_ctrl, id_ex_valid, stall_count, flush_count); end
    #1 rst_n = 1'b1;
    step();
    checks++; if (im_addr !== 32'h4 || if_id_instr !== 32'h2008_0001) begin errors++; $display("FAIL async_rst_resume got %h/%h exp 4/20080001", im_addr, if_id_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load_use_stall();
    test_branch();
    test_branch_held();
    test_jump_priority();
    test_wrap();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
